alu_op_sequencer: RTL and testbench

Multi-cycle controller that evaluates small linear combinations of two 16-bit operands (A+B, A−B, 3A−2B, 2A+B) on one shared 16-bit adder-subtractor. It latches a request, issues one add/subtract step per clock to the single datapath unit, accumulates sticky status flags, and returns the result with a done pulse. It replaces per-term adder chains in the arithmetic section, so one adder-subtractor instance serves every multi-term expression.

---
 rtl/alu_op_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-step linear-combination sequencer on one shared 16-bit add/sub unit
//
// Evaluates A+B, A-B, 3A-2B or 2A+B by issuing one add/subtract step per clock
// to a single adder-subtractor, accumulating sticky status flags.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        request strobe, sampled in IDLE and DONE only
//   op           00 ADD, 01 SUB, 10 3A-2B, 11 2A+B
//   signed_mode  1 = signed overflow flag, 0 = unsigned carry/borrow flags
//   a, b         16-bit operands, latched on accept
//   result       accumulator T, held until the first step of the next request
//   carry        sticky unsigned carry
//   borrow       sticky unsigned borrow
//   overflow     sticky signed overflow
//   busy         high while steps execute
//   done         one-cycle pulse when result and flags are final
module alu_op_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        signed_mode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        carry,
    output logic        borrow,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_TMD = 2'b10;
    localparam logic [1:0] OP_DPB = 2'b11;

    state_t      state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [1:0]  op_q;
    logic        sm_q;
    logic [1:0]  step;

    // Operand selection for the current step; the accumulator T is the result register.
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic        last;

    always_comb begin
        x    = result;
        y    = b_q;
        sub  = 1'b0;
        last = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                x    = a_q;
                last = 1'b1;
            end
            OP_SUB: begin
                x    = a_q;
                sub  = 1'b1;
                last = 1'b1;
            end
            OP_TMD: begin
                unique case (step)
                    2'd0: begin
                        x = a_q;
                        y = a_q;
                    end
                    2'd1: y = a_q;
                    2'd2: sub = 1'b1;
                    2'd3: begin
                        sub  = 1'b1;
                        last = 1'b1;
                    end
                endcase
            end
            OP_DPB: begin
                if (step == 2'd0) begin
                    x = a_q;
                    y = a_q;
                end else begin
                    last = 1'b1;
                end
            end
        endcase
    end

    // The single shared adder-subtractor: subtraction is X + ~Y + 1.
    logic [15:0] sum;
    logic        cout;
    logic        step_ovf;

    assign {cout, sum} = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {16'b0, sub};

    // Y's sign is compared in its original (non-inverted) form.
    assign step_ovf = (sum[15] != x[15]) && (sub ? (x[15] != y[15]) : (x[15] == y[15]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            op_q     <= OP_ADD;
            sm_q     <= 1'b0;
            step     <= 2'd0;
            result   <= 16'h0000;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // result is deliberately left untouched until the first step.
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        sm_q     <= signed_mode;
                        step     <= 2'd0;
                        carry    <= 1'b0;
                        borrow   <= 1'b0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_EXEC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    result <= sum;
                    step   <= step + 2'd1;
                    if (sm_q) begin
                        overflow <= overflow | step_ovf;
                    end else if (sub) begin
                        borrow <= borrow | ~cout;
                    end else begin
                        carry <= carry | cout;
                    end
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with behavioural model
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        signed_mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        carry;
    logic        borrow;
    logic        overflow;
    logic        busy;
    logic        done;

    alu_op_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .result      (result),
        .carry       (carry),
        .borrow      (borrow),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nsteps(input logic [1:0] o);
        case (o)
            2'b10:   return 4;
            2'b11:   return 2;
            default: return 1;
        endcase
    endfunction

    // Evaluates the expression left to right as a chain of integer terms
    // starting from A, judging flags from integer range rather than bits.
    function automatic void eval(input logic [1:0] o, input logic sm,
                                 input logic [15:0] va, input logic [15:0] vb,
                                 output logic [15:0] r, output logic c,
                                 output logic bo, output logic ov);
        int use_b [4];
        int neg   [4];
        int n;
        int acc;
        int sacc;
        int v;
        int sv;
        int s;
        c = 0; bo = 0; ov = 0;
        case (o)
            2'b00: begin n = 1; use_b = '{1, 0, 0, 0}; neg = '{0, 0, 0, 0}; end
            2'b01: begin n = 1; use_b = '{1, 0, 0, 0}; neg = '{1, 0, 0, 0}; end
            2'b10: begin n = 4; use_b = '{0, 0, 1, 1}; neg = '{0, 0, 1, 1}; end
            default: begin n = 2; use_b = '{0, 1, 0, 0}; neg = '{0, 0, 0, 0}; end
        endcase
        acc  = int'(va);
        sacc = int'($signed(va));
        for (int i = 0; i < n; i++) begin
            v  = use_b[i] ? int'(vb) : int'(va);
            sv = use_b[i] ? int'($signed(vb)) : int'($signed(va));
            if (neg[i] != 0) begin
                if (acc < v) bo = 1;
                acc = (acc - v + 65536) % 65536;
                s = sacc - sv;
            end else begin
                if (acc + v > 65535) c = 1;
                acc = (acc + v) % 65536;
                s = sacc + sv;
            end
            if (s > 32767 || s < -32768) ov = 1;
            sacc = ((s + 32768 + 65536) % 65536) - 32768;
        end
        r = acc[15:0];
        if (sm) begin c = 0; bo = 0; end
        else ov = 0;
    endfunction

    // Cycle-level model: a countdown of remaining steps plus the expected final values.
    int          m_rem  = 0;
    logic        m_busy = 0;
    logic        m_done = 0;
    logic [15:0] m_res  = 0;
    logic        m_c = 0, m_b = 0, m_o = 0;
    logic [15:0] p_res;
    logic        p_c, p_b, p_o;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem = 0; m_busy = 0; m_done = 0;
            m_res = 0; m_c = 0; m_b = 0; m_o = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0; m_done = 1;
                m_res = p_res; m_c = p_c; m_b = p_b; m_o = p_o;
            end
        end else begin
            m_done = 0;
            if (start) begin
                eval(op, signed_mode, a, b, p_res, p_c, p_b, p_o);
                m_rem = nsteps(op);
                m_busy = 1;
                m_c = 0; m_b = 0; m_o = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (!m_busy) begin
                chk("result", result, m_res);
                chk("carry", carry, m_c);
                chk("borrow", borrow, m_b);
                chk("overflow", overflow, m_o);
            end
        end
    end

    // Caller is at #1 after an edge; the request is accepted on the next edge.
    task automatic req(input logic [1:0] o, input logic sm, input logic [15:0] va, input logic [15:0] vb);
        op = o; signed_mode = sm; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (lat > 20) begin
                chk("done_timeout", 32'(lat), 0);
                break;
            end
        end
    endtask

    task automatic lit(input string name, input int lat, input int n, input logic [15:0] r,
                       input logic c, input logic bo, input logic ov);
        chk({name, "_lat"}, 32'(lat), 32'(n));
        chk({name, "_res"}, result, r);
        chk({name, "_c"}, carry, c);
        chk({name, "_b"}, borrow, bo);
        chk({name, "_o"}, overflow, ov);
    endtask

    initial begin
        int          lat;
        logic [15:0] er;
        logic        ec, eb, eo;

        reset = 1'b1; start = 1'b0; op = 2'b00; signed_mode = 1'b0; a = 0; b = 0;

        // Pin the model against hand-worked values.
        eval(2'b10, 1'b0, 16'd5, 16'd3, er, ec, eb, eo);
        chk("model_tmd", {er, 1'b0, ec, eb, eo}, {16'h0009, 4'b0000});
        eval(2'b10, 1'b1, 16'h3000, 16'hE000, er, ec, eb, eo);
        chk("model_sovf", {er, 1'b0, ec, eb, eo}, {16'hD000, 4'b0001});
        eval(2'b01, 1'b0, 16'h0000, 16'h0001, er, ec, eb, eo);
        chk("model_sub", {er, 1'b0, ec, eb, eo}, {16'hFFFF, 4'b0010});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {result, carry, borrow, overflow, busy, done}, 21'h0);
        reset = 1'b0;

        @(posedge clk); #1;
        req(2'b10, 1'b0, 16'd5, 16'd3);
        wait_done(lat);
        lit("tmd_u", lat, 4, 16'h0009, 0, 0, 0);

        @(posedge clk); #1;
        req(2'b10, 1'b0, 16'd1, 16'd2);
        wait_done(lat);
        lit("tmd_borrow", lat, 4, 16'hFFFF, 0, 1, 0);

        @(posedge clk); #1;
        req(2'b10, 1'b1, 16'h3000, 16'hE000);
        wait_done(lat);
        lit("tmd_sovf", lat, 4, 16'hD000, 0, 0, 1);

        // Back-to-back: second start is presented while done is high.
        @(posedge clk); #1;
        req(2'b00, 1'b0, 16'hFFFF, 16'h0001);
        wait_done(lat);
        lit("b2b_first", lat, 1, 16'h0000, 1, 0, 0);
        req(2'b01, 1'b0, 16'h0000, 16'h0001);
        chk("b2b_held_res", result, 16'h0000);
        chk("b2b_flags_clr", carry, 1'b0);
        wait_done(lat);
        lit("b2b_second", lat, 1, 16'hFFFF, 0, 1, 0);

        @(posedge clk); #1;
        req(2'b11, 1'b1, 16'h7FFF, 16'h0001);
        wait_done(lat);
        lit("dpb_s", lat, 2, 16'hFFFF, 0, 0, 1);

        // Start pulsed mid-execution with different operands must be ignored.
        @(posedge clk); #1;
        req(2'b10, 1'b0, 16'd5, 16'd3);
        a = 16'd100; b = 16'd7; op = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        lit("ignore_start", lat + 1, 4, 16'h0009, 0, 0, 0);

        // Reset between step 1 and step 2.
        @(posedge clk); #1;
        req(2'b10, 1'b1, 16'h3000, 16'hE000);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("midrst_outputs", {result, carry, borrow, overflow, busy, done}, 21'h0);
        // Start held across reset release is sampled on the first edge after it.
        op = 2'b00; signed_mode = 1'b0; a = 16'h1234; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        lit("post_rst", lat, 1, 16'h1235, 0, 0, 0);

        // Randomised traffic, including starts during execution.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            start       = 1'($urandom_range(0, 1));
            op          = 2'($urandom_range(0, 3));
            signed_mode = 1'($urandom_range(0, 1));
            a           = 16'($urandom);
            b           = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
